// File: rtl/lr_car_detector.sv
// Local-road queue detector: synchronizes and debounces the arrival and departure
// loop sensors, counts queued cars on debounced rising edges, and flags a lost arrival.
module lr_car_detector #(
   parameter int DEB_CYC = 4,
   parameter int CNT_W   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             arrive_raw,
   input  logic             depart_raw,
   output logic             lr_has_car,
   output logic [CNT_W-1:0] car_count,
   output logic             overflow
);

   localparam int               DW      = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
   localparam logic [DW-1:0]    DCNT_TC = DW'(DEB_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Channel index 0 = arrival loop, 1 = departure loop.
   logic [1:0]       sync1_q, sync1_d;
   logic [1:0]       sync2_q, sync2_d;
   logic [1:0]       deb_q, deb_d;
   logic [1:0]       ev;
   logic [DW-1:0]    dcnt_q [2];
   logic [DW-1:0]    dcnt_d [2];
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;

   always_comb begin
      sync1_d = {depart_raw, arrive_raw};
      sync2_d = sync1_q;
      deb_d   = deb_q;
      ev      = '0;
      for (int i = 0; i < 2; i++) begin
         dcnt_d[i] = '0;
         if (sync2_q[i] != deb_q[i]) begin
            if (dcnt_q[i] == DCNT_TC) begin
               deb_d[i] = sync2_q[i];
               ev[i]    = sync2_q[i];
            end else begin
               dcnt_d[i] = dcnt_q[i] + 1'b1;
            end
         end
      end
   end

   // Simultaneous arrival and departure cancel out and leave overflow untouched.
   always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (ev[0] && !ev[1]) begin
         if (cnt_q == CNT_MAX) begin
            ovf_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else if (ev[1] && !ev[0] && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         deb_q     <= '0;
         dcnt_q[0] <= '0;
         dcnt_q[1] <= '0;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         deb_q     <= deb_d;
         dcnt_q[0] <= dcnt_d[0];
         dcnt_q[1] <= dcnt_d[1];
         cnt_q     <= cnt_d;
         ovf_q     <= ovf_d;
      end
   end

   assign car_count  = cnt_q;
   assign lr_has_car = (cnt_q != '0);
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_lr_car_detector.sv
// Directed bench for lr_car_detector (DEB_CYC=4, CNT_W=4) with hand-computed expectations.
module tb_lr_car_detector;

   logic       clk;
   logic       rst_n;
   logic       arrive_raw;
   logic       depart_raw;
   logic       lr_has_car;
   logic [3:0] car_count;
   logic       overflow;

   int n_chk;
   int n_err;

   lr_car_detector #(.DEB_CYC(4), .CNT_W(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .arrive_raw (arrive_raw),
      .depart_raw (depart_raw),
      .lr_has_car (lr_has_car),
      .car_count  (car_count),
      .overflow   (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp_v);
      n_chk++;
      if (obs != exp_v) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic chk_all(input string tag, input int cnt, input int ovf);
      chk({tag, "_cnt"}, int'(car_count), cnt);
      chk({tag, "_has"}, int'(lr_has_car), (cnt != 0) ? 1 : 0);
      chk({tag, "_ovf"}, int'(overflow), ovf);
   endtask

   task automatic arrival();
      @(negedge clk) arrive_raw = 1'b1;
      repeat (8) @(negedge clk);
      arrive_raw = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic departure();
      @(negedge clk) depart_raw = 1'b1;
      repeat (8) @(negedge clk);
      depart_raw = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk) rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      n_chk      = 0;
      n_err      = 0;
      rst_n      = 1'b0;
      arrive_raw = 1'b0;
      depart_raw = 1'b0;
      repeat (3) @(negedge clk);
      chk_all("rst_init", 0, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Single arrival: update exactly at edge 6.
      @(negedge clk) arrive_raw = 1'b1;
      for (int e = 1; e <= 5; e++) begin
         @(posedge clk); #1;
         chk($sformatf("arr_lat_e%0d", e), int'(car_count), 0);
         chk($sformatf("arr_has_e%0d", e), int'(lr_has_car), 0);
      end
      @(posedge clk); #1;
      chk("arr_lat_e6", int'(car_count), 1);
      chk("arr_has_e6", int'(lr_has_car), 1);
      repeat (100) @(negedge clk);
      chk_all("arr_hold", 1, 0);
      arrive_raw = 1'b0;
      repeat (8) @(negedge clk);

      // Single departure: same latency.
      @(negedge clk) depart_raw = 1'b1;
      for (int e = 1; e <= 5; e++) begin
         @(posedge clk); #1;
         chk($sformatf("dep_lat_e%0d", e), int'(car_count), 1);
      end
      @(posedge clk); #1;
      chk("dep_lat_e6", int'(car_count), 0);
      chk("dep_has_e6", int'(lr_has_car), 0);
      @(negedge clk) depart_raw = 1'b0;
      repeat (8) @(negedge clk);

      // Bounce: 3 high / 1 low never reaches the 4-cycle run.
      for (int k = 0; k < 10; k++) begin
         arrive_raw = 1'b1;
         repeat (3) @(negedge clk);
         arrive_raw = 1'b0;
         @(negedge clk);
      end
      repeat (8) @(negedge clk);
      chk_all("bounce", 0, 0);
      arrive_raw = 1'b1;
      repeat (8) @(negedge clk);
      chk_all("bounce_hold", 1, 0);
      arrive_raw = 1'b0;
      repeat (8) @(negedge clk);

      // Reset mid-count.
      arrival();
      arrival();
      chk_all("pre_rst", 3, 0);
      @(negedge clk) rst_n = 1'b0;
      #1;
      chk_all("rst_async", 0, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk_all("rst_release", 0, 0);

      // Queue drain.
      for (int k = 1; k <= 3; k++) begin
         arrival();
         chk_all($sformatf("drain_up%0d", k), k, 0);
      end
      for (int k = 2; k >= 0; k--) begin
         departure();
         chk_all($sformatf("drain_dn%0d", k), k, 0);
      end
      departure();
      chk_all("drain_extra", 0, 0);

      // Simultaneous arrival and departure.
      arrival();
      arrival();
      @(negedge clk);
      arrive_raw = 1'b1;
      depart_raw = 1'b1;
      for (int e = 1; e <= 6; e++) begin
         @(posedge clk); #1;
         chk($sformatf("simul_e%0d", e), int'(car_count), 2);
      end
      repeat (6) @(negedge clk);
      arrive_raw = 1'b0;
      depart_raw = 1'b0;
      repeat (8) @(negedge clk);
      chk_all("simul_after", 2, 0);

      // Saturation and sticky overflow.
      do_reset();
      for (int k = 1; k <= 16; k++) begin
         arrival();
         chk_all($sformatf("sat_a%0d", k), (k > 15) ? 15 : k, (k == 16) ? 1 : 0);
      end
      for (int k = 14; k >= 0; k--) begin
         departure();
         chk_all($sformatf("sat_d%0d", k), k, 1);
      end
      departure();
      chk_all("sat_empty", 0, 1);
      do_reset();
      chk_all("sat_rst", 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #2000000;
      n_err++;
      $display("FAIL timeout: got 0 expected 1 (simulation did not complete)");
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $fatal(1, "timeout");
   end

endmodule
